// File: rtl/act_sram_pkg.sv
// Shared defaults and state encoding for the activation SRAM with pipelined reads
// and a background clear engine.
package act_sram_pkg;

  localparam int CH_NUM_DEF       = 3;
  localparam int ACT_PER_ADDR_DEF = 9;
  localparam int BW_PER_ACT_DEF   = 10;
  localparam int DEPTH_DEF        = 480;
  localparam int RD_LAT_DEF       = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/act_sram_pipe_if.sv
// Host-side bus of the activation SRAM: write/read request signals, read return
// and clear-engine control/status.
interface act_sram_pipe_if #(
  parameter int N  = 27,
  parameter int W  = 270,
  parameter int AW = 9
);
  logic          csb;
  logic          wsb;
  logic [N-1:0]  wordmask;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [AW-1:0] raddr;
  logic          rd_en;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          raddr_err;
  logic          clr_start;
  logic          busy;
  logic          clr_done;

  modport master (
    output csb, wsb, wordmask, waddr, wdata, raddr, rd_en, clr_start,
    input  rdata, rvalid, raddr_err, busy, clr_done
  );

  modport slave (
    input  csb, wsb, wordmask, waddr, wdata, raddr, rd_en, clr_start,
    output rdata, rvalid, raddr_err, busy, clr_done
  );
endinterface

// File: rtl/act_sram_rd_pipe.sv
// RD_LAT-deep delay line for read valid/data/error; the data stages only load
// on a valid entry so the final rdata holds its last returned word.
module act_sram_rd_pipe #(
  parameter int W      = 270,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         err_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         err_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] err_q;
  logic [W-1:0]      data_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int s = 0; s < RD_LAT; s++) data_q[s] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= valid_i & err_i;
      if (valid_i) data_q[0] <= data_i;
      for (int s = 1; s < RD_LAT; s++) begin
        valid_q[s] <= valid_q[s-1];
        err_q[s]   <= err_q[s-1];
        if (valid_q[s-1]) data_q[s] <= data_q[s-1];
      end
    end
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign err_o   = err_q[RD_LAT-1];
  assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/act_sram_pipe.sv
// Activation SRAM with per-activation write masking, write-first collision
// forwarding, pipelined reads and a one-word-per-cycle clear engine.
module act_sram_pipe
  import act_sram_pkg::*;
#(
  parameter int CH_NUM       = CH_NUM_DEF,
  parameter int ACT_PER_ADDR = ACT_PER_ADDR_DEF,
  parameter int BW_PER_ACT   = BW_PER_ACT_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int RD_LAT       = RD_LAT_DEF
) (
  input logic           clk,
  input logic           rst,
  act_sram_pipe_if.slave bus
);

  localparam int N  = CH_NUM * ACT_PER_ADDR;
  localparam int W  = N * BW_PER_ACT;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  clr_state_e    state_q;
  logic [AW-1:0] ctr_q;
  logic [AW-1:0] ctrNext;
  logic          busy_q;
  logic          clrDone_q;

  logic [W-1:0] bitMask;
  logic [W-1:0] wrWord;
  logic [W-1:0] rdWord;
  logic         wrInRange;
  logic         rdInRange;
  logic         wrAcc;
  logic         rdAcc;

  always_comb begin
    bitMask = '0;
    for (int i = 0; i < N; i++)
      bitMask[i*BW_PER_ACT +: BW_PER_ACT] = {BW_PER_ACT{bus.wordmask[i]}};
  end

  assign wrInRange = int'(bus.waddr) < DEPTH;
  assign rdInRange = int'(bus.raddr) < DEPTH;
  assign wrAcc     = ~bus.csb & ~bus.wsb & ~busy_q & wrInRange;
  assign rdAcc     = ~bus.csb & bus.rd_en & ~busy_q;
  assign wrWord    = (bus.wdata & ~bitMask) | (mem[bus.waddr] & bitMask);
  assign ctrNext   = ctr_q + AW'(1);

  // Same-cycle write to the read address forwards the merged word (write-first).
  always_comb begin
    rdWord = '0;
    if (rdInRange) begin
      if (wrAcc && (bus.waddr == bus.raddr)) rdWord = wrWord;
      else                                   rdWord = mem[bus.raddr];
    end
  end

  // Memory contents survive reset; reset only blocks the write in its own cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) mem[ctr_q] <= '0;
      else if (wrAcc)       mem[bus.waddr] <= wrWord;
    end
  end

  // clr_done is raised one cycle early so it lines up with the final clear write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ctr_q     <= '0;
      busy_q    <= 1'b0;
      clrDone_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clrDone_q <= 1'b0;
          if (bus.clr_start) begin
            state_q   <= CLEAR;
            ctr_q     <= '0;
            busy_q    <= 1'b1;
            clrDone_q <= (DEPTH == 1);
          end
        end
        CLEAR: begin
          if (ctr_q == LAST) begin
            state_q   <= IDLE;
            ctr_q     <= '0;
            busy_q    <= 1'b0;
            clrDone_q <= 1'b0;
          end else begin
            ctr_q     <= ctrNext;
            clrDone_q <= (ctrNext == LAST);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.clr_done = clrDone_q;

  act_sram_rd_pipe #(
    .W      (W),
    .RD_LAT (RD_LAT)
  ) uRdPipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rdAcc),
    .data_i  (rdWord),
    .err_i   (~rdInRange),
    .valid_o (bus.rvalid),
    .data_o  (bus.rdata),
    .err_o   (bus.raddr_err)
  );

  // Backdoor loaders for simulation setup; not used by the datapath.
  task automatic preloadWord(input logic [AW-1:0] addr, input logic [W-1:0] data);
    mem[addr] <= data;
  endtask

  task automatic preloadAct(input logic [AW-1:0] addr, input int idx,
                            input logic [BW_PER_ACT-1:0] act);
    mem[addr][idx*BW_PER_ACT +: BW_PER_ACT] <= act;
  endtask

endmodule

// File: tb/tb_act_sram_pipe.sv
// Directed bench: a default-parameter instance (DEPTH 480, RD_LAT 1) and a small
// instance (DEPTH 16, RD_LAT 3) for latency and clear-engine behaviour.
module tb_act_sram_pipe;

  localparam int N   = 27;
  localparam int BW  = 10;
  localparam int W   = 270;
  localparam int AWA = 9;
  localparam int AWB = 4;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  act_sram_pipe_if #(.N(N), .W(W), .AW(AWA)) ifA ();
  act_sram_pipe_if #(.N(N), .W(W), .AW(AWB)) ifB ();

  act_sram_pipe uDutA (
    .clk (clk),
    .rst (rstA),
    .bus (ifA)
  );

  act_sram_pipe #(
    .DEPTH  (16),
    .RD_LAT (3)
  ) uDutB (
    .clk (clk),
    .rst (rstB),
    .bus (ifB)
  );

  function automatic logic [W-1:0] fill(input logic [BW-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyIdleA();
    ifA.csb = 1'b1; ifA.wsb = 1'b1; ifA.rd_en = 1'b0; ifA.clr_start = 1'b0;
    ifA.wordmask = '0; ifA.waddr = '0; ifA.wdata = '0; ifA.raddr = '0;
  endtask

  task automatic applyWriteA(input logic [AWA-1:0] a, input logic [W-1:0] d, input logic [N-1:0] m);
    ifA.csb = 1'b0; ifA.wsb = 1'b0; ifA.waddr = a; ifA.wdata = d; ifA.wordmask = m;
  endtask

  task automatic applyReadA(input logic [AWA-1:0] a);
    ifA.csb = 1'b0; ifA.rd_en = 1'b1; ifA.raddr = a;
  endtask

  task automatic applyIdleB();
    ifB.csb = 1'b1; ifB.wsb = 1'b1; ifB.rd_en = 1'b0; ifB.clr_start = 1'b0;
    ifB.wordmask = '0; ifB.waddr = '0; ifB.wdata = '0; ifB.raddr = '0;
  endtask

  task automatic applyWriteB(input logic [AWB-1:0] a, input logic [W-1:0] d, input logic [N-1:0] m);
    ifB.csb = 1'b0; ifB.wsb = 1'b0; ifB.waddr = a; ifB.wdata = d; ifB.wordmask = m;
  endtask

  task automatic applyReadB(input logic [AWB-1:0] a);
    ifB.csb = 1'b0; ifB.rd_en = 1'b1; ifB.raddr = a;
  endtask

  initial begin
    logic [W-1:0] expWord;

    applyIdleA();
    applyIdleB();
    rstA = 1'b1;
    rstB = 1'b1;
    tick();
    tick();
    checkOutput("rstA_rvalid", ifA.rvalid, '0);
    checkOutput("rstA_err", ifA.raddr_err, '0);
    checkOutput("rstA_rdata", ifA.rdata, '0);
    checkOutput("rstA_busy", ifA.busy, '0);
    checkOutput("rstA_clr_done", ifA.clr_done, '0);
    checkOutput("rstB_rvalid", ifB.rvalid, '0);
    checkOutput("rstB_err", ifB.raddr_err, '0);
    checkOutput("rstB_rdata", ifB.rdata, '0);
    checkOutput("rstB_busy", ifB.busy, '0);
    checkOutput("rstB_clr_done", ifB.clr_done, '0);
    rstA = 1'b0;
    rstB = 1'b0;

    // Masked write: only activation 0 keeps its old all-ones value.
    applyWriteA(9'd5, {W{1'b1}}, '0);
    tick();
    applyIdleA();
    applyWriteA(9'd5, '0, 27'h1);
    tick();
    applyIdleA();
    applyReadA(9'd5);
    tick();
    applyIdleA();
    checkOutput("mask_rvalid", ifA.rvalid, 1'b1);
    checkOutput("mask_rdata", ifA.rdata, 270'h3FF);
    checkOutput("mask_err", ifA.raddr_err, 1'b0);
    tick();
    checkOutput("hold_rvalid", ifA.rvalid, 1'b0);
    checkOutput("hold_rdata", ifA.rdata, 270'h3FF);

    // Collision: same-cycle write and read of address 7 returns the merged word.
    applyWriteA(9'd7, {W{1'b1}}, '0);
    tick();
    applyIdleA();
    applyWriteA(9'd7, fill(10'h2AA), 27'h2);
    applyReadA(9'd7);
    tick();
    applyIdleA();
    expWord = fill(10'h2AA);
    expWord[19:10] = 10'h3FF;
    checkOutput("coll_rvalid", ifA.rvalid, 1'b1);
    checkOutput("coll_rdata", ifA.rdata, expWord);
    applyReadA(9'd7);
    tick();
    applyIdleA();
    checkOutput("coll_stored", ifA.rdata, expWord);

    // Out-of-range accesses and the last legal address.
    applyWriteA(9'd479, fill(10'h155), '0);
    tick();
    applyIdleA();
    applyReadA(9'd480);
    tick();
    applyIdleA();
    checkOutput("oor_rvalid", ifA.rvalid, 1'b1);
    checkOutput("oor_err", ifA.raddr_err, 1'b1);
    checkOutput("oor_rdata", ifA.rdata, '0);
    applyWriteA(9'd500, fill(10'h0F0), '0);
    tick();
    applyIdleA();
    applyReadA(9'd479);
    tick();
    applyIdleA();
    checkOutput("last_rdata", ifA.rdata, fill(10'h155));
    checkOutput("last_err", ifA.raddr_err, 1'b0);
    applyReadA(9'd5);
    tick();
    applyIdleA();
    checkOutput("oorw_addr5", ifA.rdata, 270'h3FF);
    applyReadA(9'd7);
    tick();
    applyIdleA();
    checkOutput("oorw_addr7", ifA.rdata, expWord);

    // Latency: four back-to-back reads on the RD_LAT=3 instance.
    for (int k = 0; k < 4; k++) begin
      applyIdleB();
      applyWriteB(AWB'(k), fill(BW'(16 + k)), '0);
      tick();
    end
    for (int t = 0; t < 8; t++) begin
      applyIdleB();
      if (t < 4) applyReadB(AWB'(t));
      checkOutput($sformatf("lat_rvalid_t%0d", t), ifB.rvalid, (t >= 3 && t <= 6));
      if (t >= 3 && t <= 6) checkOutput($sformatf("lat_rdata_t%0d", t), ifB.rdata, fill(BW'(16 + t - 3)));
      if (t == 7) checkOutput("lat_hold", ifB.rdata, fill(BW'(19)));
      tick();
    end

    // Clear: preload, read issued just before clr_start, requests during busy dropped.
    for (int a = 0; a < 16; a++) begin
      applyIdleB();
      applyWriteB(AWB'(a), fill(BW'(512 + a)), '0);
      tick();
    end
    applyIdleB();
    applyReadB(4'd1);
    tick();
    for (int t = 0; t <= 17; t++) begin
      applyIdleB();
      if (t == 0 || t == 6) ifB.clr_start = 1'b1;
      if (t == 5) applyReadB(4'd4);
      if (t == 10) applyWriteB(4'd2, {W{1'b1}}, '0);
      checkOutput($sformatf("clr_busy_t%0d", t), ifB.busy, (t >= 1 && t <= 16));
      checkOutput($sformatf("clr_done_t%0d", t), ifB.clr_done, (t == 16));
      checkOutput($sformatf("clr_rvalid_t%0d", t), ifB.rvalid, (t == 2));
      if (t == 2) checkOutput("clr_preread", ifB.rdata, fill(BW'(513)));
      tick();
    end
    for (int t = 0; t < 19; t++) begin
      applyIdleB();
      if (t < 16) applyReadB(AWB'(t));
      if (t >= 3) begin
        checkOutput($sformatf("clr_rb_rvalid_%0d", t - 3), ifB.rvalid, 1'b1);
        checkOutput($sformatf("clr_rb_rdata_%0d", t - 3), ifB.rdata, '0);
      end
      tick();
    end

    // Reset while clearing at ctr=8 aborts the clear.
    for (int a = 0; a < 16; a++) begin
      applyIdleB();
      applyWriteB(AWB'(a), fill(BW'(256 + a)), '0);
      tick();
    end
    for (int t = 0; t <= 20; t++) begin
      applyIdleB();
      rstB = 1'b0;
      if (t == 0) ifB.clr_start = 1'b1;
      if (t == 9) rstB = 1'b1;
      checkOutput($sformatf("abort_busy_t%0d", t), ifB.busy, (t >= 1 && t <= 9));
      checkOutput($sformatf("abort_done_t%0d", t), ifB.clr_done, 1'b0);
      tick();
    end
    rstB = 1'b0;
    for (int t = 0; t < 19; t++) begin
      applyIdleB();
      if (t < 16) applyReadB(AWB'(t));
      if (t >= 3) begin
        checkOutput($sformatf("abort_rb_rdata_%0d", t - 3), ifB.rdata,
                    (t - 3 < 8) ? '0 : fill(BW'(256 + t - 3)));
      end
      tick();
    end
    applyIdleB();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
